// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request arbiter: FSM encoding,
// opcode values and the packed fixed-point operand layout.
package fpu_pkg;

    localparam int unsigned OPND_W = 17;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned RES_W  = 32;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_MUL = 2'd2;
    localparam logic [OP_W-1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic       sign;
        logic [7:0] int_part;
        logic [7:0] frac;
    } operand_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_i+1 upward (wrapping)
// and returns a one-hot grant, or zero when nothing is requesting.
module rr_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((32'(last_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin front end sharing one FPU core among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OPND_W-1:0] req_a,
    input  logic [NUM_REQ*OPND_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      rsp_err,
    output logic                      fpu_start,
    output logic                      fpu_sign_a,
    output logic                      fpu_sign_b,
    output logic [7:0]                fpu_int_a,
    output logic [7:0]                fpu_int_b,
    output logic [7:0]                fpu_frac_a,
    output logic [7:0]                fpu_frac_b,
    output logic [OP_W-1:0]           fpu_op,
    input  logic [RES_W-1:0]          fpu_result,
    input  logic                      fpu_done
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  id_q, id_d;
    operand_t         a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             start_q, start_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0] result_q, result_d;

    logic [NUM_REQ-1:0] grant;
    operand_t           sel_a, sel_b;
    logic [OP_W-1:0]    sel_op;
    logic [ID_W-1:0]    sel_id;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Accept is only offered in IDLE; gated by reset so outputs are low while held.
    assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : '0;

    // Operand/opcode/index of the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        sel_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = operand_t'(req_a[i*OPND_W +: OPND_W]);
                sel_b  = operand_t'(req_b[i*OPND_W +: OPND_W]);
                sel_op = req_op[i*OP_W +: OP_W];
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = sel_id;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_GUARD;
            // A done left high by the previous operation is masked here.
            ST_GUARD: begin
                state_d = ST_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (fpu_done) begin
                    result_d    = fpu_result;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    result_d    = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign fpu_start  = start_q;
    assign fpu_sign_a = a_q.sign;
    assign fpu_sign_b = b_q.sign;
    assign fpu_int_a  = a_q.int_part;
    assign fpu_int_b  = b_q.int_part;
    assign fpu_frac_a = a_q.frac;
    assign fpu_frac_b = b_q.frac;
    assign fpu_op     = op_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: arbitration order, latency, RESP stall,
// GUARD masking, mid-WAIT reset and (with FPU_ARB_TIMEOUT_EN) the watchdog.
module tb_fpu_arbiter;
    import fpu_pkg::*;

    localparam int unsigned N = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*OPND_W-1:0] req_a;
    logic [N*OPND_W-1:0] req_b;
    logic [N*OP_W-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [RES_W-1:0]    rsp_result;
    logic                rsp_err;
    logic                fpu_start;
    logic                fpu_sign_a, fpu_sign_b;
    logic [7:0]          fpu_int_a, fpu_int_b, fpu_frac_a, fpu_frac_b;
    logic [OP_W-1:0]     fpu_op;
    logic [RES_W-1:0]    fpu_result;
    logic                fpu_done;

    logic [OPND_W-1:0] opa [N];
    logic [OPND_W-1:0] opb [N];
    logic [OP_W-1:0]   opc [N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpu_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .fpu_start  (fpu_start),
        .fpu_sign_a (fpu_sign_a),
        .fpu_sign_b (fpu_sign_b),
        .fpu_int_a  (fpu_int_a),
        .fpu_int_b  (fpu_int_b),
        .fpu_frac_a (fpu_frac_a),
        .fpu_frac_b (fpu_frac_b),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result),
        .fpu_done   (fpu_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction starting in an IDLE cycle; returns in the next IDLE cycle.
    task automatic txn(input logic [N-1:0] valid, input int exp_id, input int n_wait,
                       input bit exp_err, input bit pre_done, input logic [31:0] res,
                       input int stall);
        logic [OPND_W-1:0] ea, eb;
        logic [N-1:0]      eg;
        ea = opa[exp_id];
        eb = opb[exp_id];
        eg = 4'b0001 << exp_id;
        req_valid  = valid;
        fpu_done   = pre_done;
        fpu_result = 32'hDEAD_BEEF;
        @(negedge clk);
        check("grant", 32'(req_ready), 32'(eg));
        check("idle_start", 32'(fpu_start), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("issue_start", 32'(fpu_start), 32'(1));
        check("issue_ready", 32'(req_ready), 32'(0));
        check("sign_a", 32'(fpu_sign_a), 32'(ea[16]));
        check("int_a", 32'(fpu_int_a), 32'(ea[15:8]));
        check("frac_a", 32'(fpu_frac_a), 32'(ea[7:0]));
        check("sign_b", 32'(fpu_sign_b), 32'(eb[16]));
        check("int_b", 32'(fpu_int_b), 32'(eb[15:8]));
        check("frac_b", 32'(fpu_frac_b), 32'(eb[7:0]));
        check("op", 32'(fpu_op), 32'(opc[exp_id]));
        @(posedge clk); #1;
        @(negedge clk);
        check("guard_start", 32'(fpu_start), 32'(0));
        check("guard_valid", 32'(rsp_valid), 32'(0));
        @(posedge clk); #1;
        for (int w = 0; w < n_wait; w++) begin
            fpu_done = 1'b0;
            @(negedge clk);
            check("wait_valid", 32'(rsp_valid), 32'(0));
            check("wait_int_a", 32'(fpu_int_a), 32'(ea[15:8]));
            @(posedge clk); #1;
        end
        if (!exp_err) begin
            fpu_done   = 1'b1;
            fpu_result = res;
            @(negedge clk);
            check("done_cyc_valid", 32'(rsp_valid), 32'(0));
            @(posedge clk); #1;
        end
        fpu_done   = pre_done;
        fpu_result = 32'hBAD0_BAD0;
        for (int s = 0; s <= stall; s++) begin
            rsp_ready = (s == stall);
            @(negedge clk);
            check("rsp_valid", 32'(rsp_valid), 32'(1));
            check("rsp_id", 32'(rsp_id), 32'(exp_id));
            check("rsp_result", rsp_result, exp_err ? 32'h0 : res);
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            check("resp_ready", 32'(req_ready), 32'(0));
            check("resp_start", 32'(fpu_start), 32'(0));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        check("rsp_clear", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        opa[0] = 17'h00300;  opb[0] = 17'h00200;  opc[0] = OP_ADD;
        opa[1] = {1'b1, 8'd10, 8'h80};  opb[1] = {1'b0, 8'd1, 8'h40};  opc[1] = OP_SUB;
        opa[2] = {1'b0, 8'd7, 8'h11};   opb[2] = {1'b1, 8'd5, 8'h22};  opc[2] = OP_MUL;
        opa[3] = {1'b1, 8'd255, 8'hFF}; opb[3] = {1'b0, 8'd0, 8'h01};  opc[3] = OP_DIV;
        for (int i = 0; i < int'(N); i++) begin
            req_a[i*OPND_W +: OPND_W] = opa[i];
            req_b[i*OPND_W +: OPND_W] = opb[i];
            req_op[i*OP_W +: OP_W]    = opc[i];
        end
        reset_n    = 1'b0;
        req_valid  = 4'b1111;
        rsp_ready  = 1'b0;
        fpu_done   = 1'b0;
        fpu_result = '0;

        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_valid", 32'(rsp_valid), 32'(0));
        check("rst_start", 32'(fpu_start), 32'(0));
        check("rst_result", rsp_result, 32'(0));
        check("rst_id", 32'(rsp_id), 32'(0));
        check("rst_err", 32'(rsp_err), 32'(0));
        check("rst_op", 32'(fpu_op), 32'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Round robin from reset, first one also the basic 3+2 add vector.
        txn(4'b1111, 0, 0, 1'b0, 1'b0, 32'h0005_0000, 0);
        txn(4'b1111, 1, 0, 1'b0, 1'b0, 32'h1111_0001, 0);
        txn(4'b1111, 2, 0, 1'b0, 1'b0, 32'h2222_0002, 0);
        txn(4'b1111, 3, 0, 1'b0, 1'b0, 32'h3333_0003, 0);
        txn(4'b1111, 0, 0, 1'b0, 1'b0, 32'h4444_0004, 0);

        // Requester 1 withdraws before an edge: no grant, no side effect.
        req_valid = 4'b0010;
        @(negedge clk);
        check("withdraw_pre", 32'(req_ready), 32'(4'b0010));
        #1 req_valid = 4'b0000;
        #1 check("withdraw_post", 32'(req_ready), 32'(0));
        @(posedge clk); #1;
        check("withdraw_start", 32'(fpu_start), 32'(0));

        txn(4'b0100, 2, 0, 1'b0, 1'b0, 32'h5555_0005, 10);
        txn(4'b1000, 3, 1, 1'b0, 1'b1, 32'h6666_0006, 0);
        txn(4'b0011, 0, 3, 1'b0, 1'b0, 32'h7777_0007, 2);
        txn(4'b0011, 1, 0, 1'b0, 1'b0, 32'h8888_0008, 0);

        // Reset pulse while waiting on the FPU.
        req_valid = 4'b1111;
        fpu_done  = 1'b0;
        @(negedge clk);
        check("rw_grant", 32'(req_ready), 32'(4'b0100));
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rw_int_a", 32'(fpu_int_a), 32'(8'd7));
        #1 reset_n = 1'b0;
        #1;
        check("rw_valid", 32'(rsp_valid), 32'(0));
        check("rw_start", 32'(fpu_start), 32'(0));
        check("rw_ready", 32'(req_ready), 32'(0));
        check("rw_int_a0", 32'(fpu_int_a), 32'(0));
        check("rw_sign_b0", 32'(fpu_sign_b), 32'(0));
        check("rw_op0", 32'(fpu_op), 32'(0));
        check("rw_result0", rsp_result, 32'(0));
        check("rw_id0", 32'(rsp_id), 32'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        txn(4'b1111, 0, 0, 1'b0, 1'b0, 32'h9999_0009, 0);

`ifdef FPU_ARB_TIMEOUT_EN
        txn(4'b0010, 1, 16, 1'b1, 1'b0, 32'h0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
